exp2_sw_driver: RTL
===================

Name: exp2_sw_driver

Overview:
- Automatic stimulus/checker for the experiment-2 gate circuit. It is the far end of the switch/LED adapters.
- Drives the active-low 32-bit switch bus with every 11-bit input vector.
- Waits for the DUT to settle, samples the active-low LED bus, and compares it against a built-in golden model.
- Sits in the board top level in place of the physical switches, for self-test and simulation sign-off.

Parameters:
- SETTLE_CYCLES, 4, clock cycles to wait after driving a vector before sampling the LEDs; legal range 1..255.
- NUM_BITS, 11, number of swept switch bits; fixed for this experiment and not to be overridden.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; starts a sweep from IDLE or DONE
- sw_a  output  32  switch bus to the DUT, active-low (1 = switch off)
- led  input  32  LED bus from the DUT, active-low (0 = lit)
- busy  output  1  high while a sweep is running
- done  output  1  high once a sweep completes; held until the next start
- pass  output  1  valid when done=1; 1 = no mismatches
- err_count  output  12  number of failing vectors, range 0..2048
- first_fail_vec  output  11  logic-true vector of the first mismatch; 0 if none

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low; the ports are named clk and rst_n.
- Reset values:
  - state = IDLE
  - sw_a = 32'hFFFF_FFFF
  - busy = 0, done = 0, pass = 0
  - err_count = 0, first_fail_vec = 0
  - internal vec = 0, settle counter = 0
- Bit map of the logic-true vector vec[10:0]:
  - bit10 mode_and, bit9 mode_or, bit8 mode_xor
  - bit7 a, bit6 b, bit5 a1, bit4 b1, bit3 a2, bit2 b2, bit1 a3, bit0 b3
- Driving: sw_a = ~{21'h0, vec}, registered. Bits [31:11] are always 1.
- Golden model: exp_e = (mode_and & a & b) | (mode_or & a) | (mode_or & b) | (mode_xor & a & ~b) | (mode_xor & ~a & b).
  - Bits a1..b3 are don't-care to the model; sweeping them checks that the DUT is independent of them.
- Expected LED bus: led == ~{31'h0, exp_e}, i.e. led[31:1] all 1 and led[0] == ~exp_e. The comparison covers all 32 bits.
- FSM states:
  - IDLE: start → clear err_count, first_fail_vec, pass; vec = 0; go to DRIVE. busy = 0.
  - DRIVE (1 cycle): register sw_a from vec; load settle counter = SETTLE_CYCLES; go to SETTLE.
  - SETTLE: decrement the counter each cycle; when it reaches 0 go to CHECK. sw_a is held stable.
  - CHECK (1 cycle): sample led and compare. On mismatch, increment err_count; if err_count was 0, capture first_fail_vec = vec.
    - If vec == 11'h7FF, go to DONE.
    - Otherwise vec = vec + 1 and go to DRIVE.
  - DONE: done = 1, busy = 0, pass = (err_count == 0); sw_a returns to all-ones. start → same clear actions as in IDLE, then DRIVE.
- busy = 1 in DRIVE, SETTLE and CHECK.
- Per-vector latency: SETTLE_CYCLES + 2 cycles. A full sweep is 2048 × (SETTLE_CYCLES + 2) cycles from the start cycle to the first done cycle; 12288 cycles at the default setting.
- Boundary conditions:
  - start while busy: ignored.
  - start in the same cycle as the final CHECK: ignored; the FSM enters DONE.
  - vec does not wrap: the sweep stops after 11'h7FF.
  - err_count cannot overflow: 12 bits holds the maximum of 2048.
  - Reset mid-sweep: immediate return to reset values. sw_a goes to all-ones asynchronously.
  - led is sampled only in CHECK; glitches during SETTLE are ignored.
  - done drops in the cycle after an accepted start.

Decomposition:
- Shared package exp2_pkg holds:
  - the FSM state enum (IDLE, DRIVE, SETTLE, CHECK, DONE)
  - localparams for the vec bit positions (MODE_AND_BIT=10 … B3_BIT=0)
  - SW_INACTIVE = 32'hFFFF_FFFF
- One sub-module: exp2_golden, combinational, vec[10:0] → exp_led[31:0]. The bench reuses it as its reference model.

Test Plan:
1. Correct behavioural DUT in the loop, start pulse → done after exactly 12288 cycles; pass=1; err_count=0; first_fail_vec=0.
2. DUT with led[0] stuck at 1 (e stuck-at-0) → err_count=1152; first_fail_vec=11'h140; pass=0.
3. DUT with led[0] stuck at 0 (e stuck-at-1) → err_count=896; first_fail_vec=11'h000. A further case with led[5] stuck at 0 → err_count=2048, which checks the upper-bit comparison.
4. Probe sw_a during SETTLE of vector 11'h140 → 32'hFFFF_FEBF, stable for all 4 SETTLE cycles. In IDLE and DONE → 32'hFFFF_FFFF.
5. Deassert rst_n at cycle 500 of a sweep → busy, done and err_count are 0 and sw_a is all-ones in the same cycle. A fresh start then completes normally with pass=1.
6. Pulse start at cycles 10 and 3000 of a running sweep → both ignored, done still arrives at cycle 12288. A start while in DONE → done drops next cycle and the sweep reruns with identical results.

Source files
------------

// File: rtl/exp2_pkg.sv
// Shared types and constants for the experiment-2 switch driver / checker.
package exp2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      SETTLE,
      CHECK,
      DONE
   } state_t;

   // Bit positions inside the logic-true vector vec[10:0]
   localparam int unsigned MODE_AND_BIT = 10;
   localparam int unsigned MODE_OR_BIT  = 9;
   localparam int unsigned MODE_XOR_BIT = 8;
   localparam int unsigned A_BIT        = 7;
   localparam int unsigned B_BIT        = 6;
   localparam int unsigned A1_BIT       = 5;
   localparam int unsigned B1_BIT       = 4;
   localparam int unsigned A2_BIT       = 3;
   localparam int unsigned B2_BIT       = 2;
   localparam int unsigned A3_BIT       = 1;
   localparam int unsigned B3_BIT       = 0;

   // Active-low switch bus with every switch off
   localparam logic [31:0] SW_INACTIVE = 32'hFFFF_FFFF;

endpackage

// File: rtl/exp2_golden.sv
// Golden model of the experiment-2 gate circuit: vector in, expected
// active-low LED bus out. Bits a1..b3 are deliberately ignored.
module exp2_golden
   import exp2_pkg::*;
(
   input  logic [10:0] vec,
   output logic [31:0] exp_led
);

   logic mode_and;
   logic mode_or;
   logic mode_xor;
   logic a;
   logic b;
   logic exp_e;
   logic unused_dont_care;

   // Evaluate the gate equation and map it onto the active-low LED bus.
   always_comb begin
      mode_and = vec[MODE_AND_BIT];
      mode_or  = vec[MODE_OR_BIT];
      mode_xor = vec[MODE_XOR_BIT];
      a        = vec[A_BIT];
      b        = vec[B_BIT];
      exp_e    = (mode_and & a & b)
               | (mode_or & a)
               | (mode_or & b)
               | (mode_xor & a & ~b)
               | (mode_xor & ~a & b);
      exp_led  = ~{31'h0, exp_e};
      unused_dont_care = ^vec[A1_BIT:B3_BIT];
   end

endmodule

// File: rtl/exp2_sw_driver.sv
// Automatic stimulus/checker for the experiment-2 gate circuit: sweeps all
// 2048 switch vectors, waits SETTLE_CYCLES, compares the LED bus with the
// golden model and reports error count and first failing vector.
module exp2_sw_driver
   import exp2_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned NUM_BITS      = 11
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [31:0] sw_a,
   input  logic [31:0] led,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [11:0] err_count,
   output logic [10:0] first_fail_vec
);

   localparam logic [NUM_BITS-1:0] VEC_LAST = '1;

   state_t              state;
   state_t              state_next;
   logic [NUM_BITS-1:0] vec;
   logic [7:0]          settle_cnt;
   logic [31:0]         golden_led;
   logic                mismatch;

   exp2_golden u_golden (
      .vec     (vec),
      .exp_led (golden_led)
   );

   assign mismatch = (led != golden_led);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; SETTLE exits on the cycle its count reaches zero.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:   if (start) state_next = DRIVE;
         DRIVE:  state_next = SETTLE;
         SETTLE: if (settle_cnt == 8'd1) state_next = CHECK;
         CHECK:  state_next = (vec == VEC_LAST) ? DONE : DRIVE;
         DONE:   if (start) state_next = DRIVE;
         default: state_next = IDLE;
      endcase
   end

   // Status outputs decoded from the current state.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      pass = 1'b0;
      case (state)
         DRIVE, SETTLE, CHECK: busy = 1'b1;
         DONE: begin
            done = 1'b1;
            pass = (err_count == '0);
         end
         default: ;
      endcase
   end

   // Sweep datapath: vector counter, switch drive, settle timer, scoring.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec            <= '0;
         settle_cnt     <= '0;
         err_count      <= '0;
         first_fail_vec <= '0;
         sw_a           <= SW_INACTIVE;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  vec            <= '0;
                  err_count      <= '0;
                  first_fail_vec <= '0;
               end
            end
            DRIVE: begin
               sw_a       <= ~{{(32-NUM_BITS){1'b0}}, vec};
               settle_cnt <= 8'(SETTLE_CYCLES);
            end
            SETTLE: begin
               settle_cnt <= settle_cnt - 8'd1;
            end
            CHECK: begin
               if (mismatch) begin
                  err_count <= err_count + 12'd1;
                  if (err_count == '0) begin
                     first_fail_vec <= vec;
                  end
               end
               if (vec == VEC_LAST) begin
                  sw_a <= SW_INACTIVE;
               end else begin
                  vec <= vec + NUM_BITS'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
